// File: rtl/poller_pkg.sv
// Shared types and default constants for the serial game-pad poller.
package poller_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLatch,
      StLow,
      StHigh,
      StDone
   } poller_state_t;

   localparam int unsigned DEF_N_BITS       = 8;
   localparam int unsigned DEF_N_PADS       = 2;
   localparam int unsigned DEF_LATCH_CYCLES = 120;
   localparam int unsigned DEF_HALF_PERIOD  = 60;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pad_shift_channel.sv
// One pad's receive channel: optional synchroniser (POLLER_SYNC_EN), inversion to
// active-high and an LSB-first shift register filled one serial bit per sample_en.
module pad_shift_channel
   import poller_pkg::*;
#(
   parameter int unsigned N_BITS = DEF_N_BITS
) (
   input  logic              clk_10MHz,
   input  logic              reset,
   input  logic              serial_in,
   input  logic              sample_en,
   input  logic              clear,
   output logic [N_BITS-1:0] word
);

   logic data_s;

`ifdef POLLER_SYNC_EN
   logic [1:0] sync_q;
   logic [1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[0], serial_in};
   end

   // Resets to the released level so a reset never looks like a press.
   always_ff @(posedge clk_10MHz or posedge reset) begin
      if (reset) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign data_s = sync_q[1];
`else
   assign data_s = serial_in;
`endif

   logic [N_BITS-1:0] word_q;
   logic [N_BITS-1:0] word_d;

   // New bits enter at the top; after N_BITS samples the first bit sits at bit 0.
   always_comb begin
      word_d = word_q;
      if (clear) begin
         word_d = '0;
      end else if (sample_en) begin
         word_d             = word_q >> 1;
         word_d[N_BITS-1]   = ~data_s;
      end
   end

   always_ff @(posedge clk_10MHz or posedge reset) begin
      if (reset) begin
         word_q <= '0;
      end else begin
         word_q <= word_d;
      end
   end

   assign word = word_q;

endmodule

// File: rtl/nes_pad_poller.sv
// Polls N_PADS serial game pads in parallel: latch pulse, N_BITS shift clocks, then an
// atomic update of all button words with a one-cycle valid strobe.
module nes_pad_poller
   import poller_pkg::*;
#(
   parameter int unsigned N_BITS       = DEF_N_BITS,
   parameter int unsigned N_PADS       = DEF_N_PADS,
   parameter int unsigned LATCH_CYCLES = DEF_LATCH_CYCLES,
   parameter int unsigned HALF_PERIOD  = DEF_HALF_PERIOD
) (
   input  logic                       clk_10MHz,
   input  logic                       reset,
   input  logic                       start,
   input  logic [N_PADS-1:0]          pad_data,
   output logic                       latch,
   output logic                       pad_clk,
   output logic [N_PADS*N_BITS-1:0]   buttons,
   output logic                       valid,
   output logic                       busy
);

   localparam int unsigned PhaseMax = max_u(max_u(LATCH_CYCLES, HALF_PERIOD), 2);
   localparam int unsigned PW       = $clog2(PhaseMax);
   localparam int unsigned BW       = $clog2(N_BITS + 1);

   localparam logic [PW-1:0] LatchLast = PW'(LATCH_CYCLES - 1);
   localparam logic [PW-1:0] HalfLast  = PW'(HALF_PERIOD - 1);
   localparam logic [BW-1:0] BitsAll   = BW'(N_BITS);

   poller_state_t state_q, state_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [BW-1:0] bit_q, bit_d;
   logic [BW-1:0] bit_next;

   logic                     latch_q, latch_d;
   logic                     pad_clk_q, pad_clk_d;
   logic                     valid_q, valid_d;
   logic                     busy_q, busy_d;
   logic [N_PADS*N_BITS-1:0] buttons_q, buttons_d;

   logic                     sample_en;
   logic                     chan_clear;
   logic [N_PADS*N_BITS-1:0] words;

   for (genvar p = 0; p < N_PADS; p++) begin : g_chan
      pad_shift_channel #(
         .N_BITS (N_BITS)
      ) u_chan (
         .clk_10MHz (clk_10MHz),
         .reset     (reset),
         .serial_in (pad_data[p]),
         .sample_en (sample_en),
         .clear     (chan_clear),
         .word      (words[p*N_BITS +: N_BITS])
      );
   end

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      bit_d      = bit_q;
      bit_next   = bit_q + 1'b1;
      sample_en  = 1'b0;
      chan_clear = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d    = StLatch;
               phase_d    = '0;
               bit_d      = '0;
               chan_clear = 1'b1;
            end
         end
         StLatch: begin
            if (phase_q == LatchLast) begin
               state_d = StLow;
               phase_d = '0;
               bit_d   = '0;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         StLow: begin
            // Sample on the last low cycle, just before the rising edge shifts the pads.
            if (phase_q == HalfLast) begin
               state_d   = StHigh;
               phase_d   = '0;
               sample_en = 1'b1;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         StHigh: begin
            if (phase_q == HalfLast) begin
               phase_d = '0;
               bit_d   = bit_next;
               state_d = (bit_next == BitsAll) ? StDone : StLow;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Outputs are registered copies of the current state, so they trail it by a cycle.
      latch_d   = (state_q == StLatch);
      pad_clk_d = (state_q != StLow);
      valid_d   = (state_q == StDone);
      busy_d    = (state_q != StIdle);
      buttons_d = (state_q == StDone) ? words : buttons_q;
   end

   always_ff @(posedge clk_10MHz or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         phase_q   <= '0;
         bit_q     <= '0;
         latch_q   <= 1'b0;
         pad_clk_q <= 1'b1;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         buttons_q <= '0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         bit_q     <= bit_d;
         latch_q   <= latch_d;
         pad_clk_q <= pad_clk_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         buttons_q <= buttons_d;
      end
   end

   assign latch   = latch_q;
   assign pad_clk = pad_clk_q;
   assign valid   = valid_q;
   assign busy    = busy_q;
   assign buttons = buttons_q;

endmodule
